// File: rtl/button_debounce_pkg.sv
// button_pkg: shared types and defaults for the button debouncer.
//   btn_state_e  - per-channel debounce FSM state
//   DEF_*        - default parameter values (27 MHz board clock)
//   cnt_width()  - bit width needed to hold 0..max_val (minimum 1)
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_NUM_BTN         = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 270000;   // 10 ms at 27 MHz
  localparam int unsigned DEF_REPEAT_DELAY    = 13500000; // 500 ms at 27 MHz
  localparam int unsigned DEF_REPEAT_PERIOD   = 2700000;  // 100 ms at 27 MHz

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// debounce_channel: one button channel -- 2-flop synchronizer, debounce FSM,
// stability counter and auto-repeat timer. All outputs are registered.
//   clk, rst       - clock, synchronous active-high reset
//   btn_n          - raw asynchronous pin, active-low
//   level          - debounced state, 1 = pressed
//   press_pulse    - one cycle on accepted press
//   release_pulse  - one cycle on accepted release
//   repeat_pulse   - one cycle auto-repeat while held
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_delay
    $error("debounce_channel: REPEAT_DELAY must be >= 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("debounce_channel: REPEAT_PERIOD must be >= 2");
  end

  localparam int unsigned TMR_MAX =
    ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int unsigned TMR_W = cnt_width(TMR_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync_q;
  logic             pressed;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             periodic_q, periodic_d;
  logic             level_d, press_d, release_d, repeat_d;
  logic             tmr_hit;

  // sync_q[1] is the only value the FSM ever looks at.
  assign pressed = ~sync_q[1];
  assign tmr_hit = periodic_q ? (tmr_q == PERIOD_LAST) : (tmr_q == DELAY_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      periodic_q    <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], btn_n};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      periodic_q    <= periodic_d;
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      repeat_pulse  <= repeat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    periodic_d = periodic_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    repeat_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = HELD;
          press_d    = 1'b1;
          tmr_d      = '0;
          periodic_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        // The timer advances on every HELD cycle, including the one that
        // leaves for RELEASE_WAIT; a bounce back to HELD resumes the count
        // instead of restarting it, so a glitch only shifts the schedule.
        if (tmr_hit) begin
          repeat_d   = 1'b1;
          tmr_d      = '0;
          periodic_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: NUM_BTN independent debounced buttons with press/release
// pulses and auto-repeat.
//   clk, rst     - clock, synchronous active-high reset
//   btn_n        - raw asynchronous pins, active-low
//   btn_level    - debounced levels, 1 = pressed
//   btn_press    - one-cycle pulse per accepted press
//   btn_release  - one-cycle pulse per accepted release
//   btn_repeat   - one-cycle auto-repeat pulses while held
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  if (NUM_BTN < 1) begin : g_bad_num
    $error("button_debounce: NUM_BTN must be >= 1");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .btn_n         (btn_n[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i]),
      .repeat_pulse  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5, NUM_BTN=2. A behavioural model tracks each channel as
// "run length of synced samples disagreeing with the debounced level" plus a
// count of held cycles since the last press.
module tb_button_debounce;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  int n_tests = 0;
  int n_fail  = 0;

  button_debounce #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [NB-1:0] m_s1 = '1, m_s2 = '1;
  logic [NB-1:0] m_level = '0, m_press = '0, m_release = '0, m_repeat = '0;
  int            m_run  [NB];
  int            m_held [NB];
  logic          mp;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '1; m_s2 = '1;
      m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
      for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_held[c] = 0; end
    end else begin
      for (int c = 0; c < NB; c++) begin
        mp = ~m_s2[c];
        m_press[c] = 1'b0; m_release[c] = 1'b0; m_repeat[c] = 1'b0;
        if (m_level[c] && m_run[c] == 0) begin
          m_held[c]++;
          if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RP == 0))
            m_repeat[c] = 1'b1;
        end
        if (mp != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DC + 1) begin
            m_level[c] = mp;
            m_run[c]   = 0;
            if (mp) begin m_press[c] = 1'b1; m_held[c] = 0; end
            else         m_release[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  end

  logic [4*NB-1:0] dut_vec, mdl_vec;
  assign dut_vec = {btn_level, btn_press, btn_release, btn_repeat};
  assign mdl_vec = {m_level, m_press, m_release, m_repeat};

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; btn_n = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (dut_vec !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs k=%0d: got %b want all zero", k, dut_vec);
      end
    end
    rst = 1'b0; btn_n = '1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (dut_vec !== mdl_vec) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d: got %b want %b", k, dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_clean_press();
    for (int k = 0; k < 30; k++) begin
      btn_n = (k >= 10) ? 2'b11 : 2'b10;
      @(posedge clk); #1;
      n_tests++;
      if (dut_vec !== mdl_vec) begin
        n_fail++;
        $display("FAIL clean_model k=%0d: got %b want %b", k, dut_vec, mdl_vec);
      end
      n_tests++;
      if (btn_press[0] !== (k == 6) || btn_level[0] !== (k >= 6 && k < 16) ||
          btn_release[0] !== (k == 16) || btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_timing k=%0d: level=%b press=%b release=%b", k,
                 btn_level, btn_press, btn_release);
      end
    end
  endtask

  task automatic test_bounce();
    int presses = 0;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       btn_n[0] = k[0];
      else if (k < 20) btn_n[0] = 1'b0;
      else             btn_n[0] = 1'b1;
      @(posedge clk); #1;
      if (btn_press[0]) presses++;
      n_tests++;
      if (dut_vec !== mdl_vec || btn_press[0] !== (k == 10)) begin
        n_fail++;
        $display("FAIL bounce k=%0d: got %b want %b press0=%b", k, dut_vec, mdl_vec, btn_press[0]);
      end
    end
    n_tests++;
    if (presses !== 1) begin
      n_fail++;
      $display("FAIL bounce_count: got %0d presses want 1", presses);
    end
  endtask

  task automatic test_repeat();
    logic exp_rep;
    for (int k = 0; k < 60; k++) begin
      btn_n[0] = (k >= 42);
      @(posedge clk); #1;
      exp_rep = (k >= 16 && k <= 41 && (k - 16) % 5 == 0);
      n_tests++;
      if (dut_vec !== mdl_vec || btn_repeat[0] !== exp_rep || btn_release[0] !== (k == 48)) begin
        n_fail++;
        $display("FAIL repeat k=%0d: got %b want %b rep0=%b exp_rep=%b", k, dut_vec, mdl_vec,
                 btn_repeat[0], exp_rep);
      end
    end
  endtask

  task automatic test_glitch();
    logic exp_rep;
    for (int k = 0; k < 60; k++) begin
      btn_n[0] = (k == 20 || k == 21 || k >= 40);
      @(posedge clk); #1;
      exp_rep = (k == 16 || k == 21 || k == 28 || k == 33 || k == 38);
      n_tests++;
      if (dut_vec !== mdl_vec || btn_repeat[0] !== exp_rep || btn_release[0] !== (k == 46)) begin
        n_fail++;
        $display("FAIL glitch k=%0d: got %b want %b rep0=%b rel0=%b", k, dut_vec, mdl_vec,
                 btn_repeat[0], btn_release[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 32; k++) begin
      btn_n[0] = (k >= 20);
      rst      = (k == 4);
      @(posedge clk); #1;
      n_tests++;
      if (dut_vec !== mdl_vec || btn_press[0] !== (k == 11) || (k == 4 && dut_vec !== '0)) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d: got %b want %b press0=%b", k, dut_vec, mdl_vec, btn_press[0]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 30; k++) begin
      btn_n = (k >= 10) ? 2'b11 : 2'b00;
      @(posedge clk); #1;
      n_tests++;
      if (dut_vec !== mdl_vec || btn_press !== ((k == 6) ? 2'b11 : 2'b00) ||
          btn_release !== ((k == 16) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL simultaneous k=%0d: got %b want %b press=%b", k, dut_vec, mdl_vec, btn_press);
      end
    end
  endtask

  task automatic test_random();
    int unsigned left [NB];
    for (int c = 0; c < NB; c++) left[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NB; c++) begin
        if (left[c] == 0) begin
          btn_n[c] = ~btn_n[c];
          left[c]  = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 7);
        end
        left[c]--;
      end
      rst = ($urandom_range(0, 249) == 0);
      @(posedge clk); #1;
      n_tests++;
      if (dut_vec !== mdl_vec) begin
        n_fail++;
        $display("FAIL random k=%0d: got %b want %b", k, dut_vec, mdl_vec);
      end
    end
    rst = 1'b0; btn_n = '1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (dut_vec !== mdl_vec) begin
        n_fail++;
        $display("FAIL random_tail k=%0d: got %b want %b", k, dut_vec, mdl_vec);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_n = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_glitch();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
